// File: rtl/ibex_csr_pulse.sv
// rtl/ibex_csr_pulse.sv - CSR primitive with masked write/set/clear, lock, hw set,
// self-clearing pulse bits and optional inverted shadow copy.
module ibex_csr_pulse #(
  parameter int unsigned      Width       = 32,
  parameter bit               ShadowCopy  = 1'b0,
  parameter logic [Width-1:0] ResetValue  = '0,
  parameter logic [Width-1:0] WriteMask   = '1,
  parameter logic [Width-1:0] PulseMask   = '0,
  parameter int unsigned      PulseCycles = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_op_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             pulse_en_i,
  input  logic             lock_i,
  input  logic [Width-1:0] hw_set_i,
  output logic [Width-1:0] rd_data_o,
  output logic             pulse_active_o,
  output logic             wr_blocked_o,
  output logic             rd_error_o
);

  localparam int unsigned     CntW    = $clog2(PulseCycles + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(PulseCycles);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  if (PulseCycles < 1) begin : g_bad_cycles
    $error("ibex_csr_pulse: PulseCycles must be at least 1");
  end
  if ((PulseMask & ~WriteMask) != '0) begin : g_bad_mask
    $error("ibex_csr_pulse: PulseMask must be a subset of WriteMask");
  end

  logic [Width-1:0] q_q, q_d, sw_val, wdata_m, shadow_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             blocked_q;
  logic             wr_valid, wr_accept, wr_blocked, arm, expiry;

  always_comb begin
    wr_valid   = wr_en_i && (wr_op_i != 2'b11);
    wr_accept  = wr_valid && !lock_i;
    wr_blocked = wr_valid && lock_i;
    wdata_m    = wr_data_i & WriteMask;
    sw_val     = q_q;
    if (wr_accept) begin
      case (wr_op_i)
        2'b00:   sw_val = (q_q & ~WriteMask) | wdata_m;
        2'b01:   sw_val = q_q | wdata_m;
        2'b10:   sw_val = q_q & ~wdata_m;
        default: sw_val = q_q;
      endcase
    end

    // An arm on the last countdown cycle wins over the pending clear.
    arm    = wr_accept && pulse_en_i && ((sw_val & PulseMask) != '0);
    expiry = (cnt_q == CntOne) && !arm;

    if (arm) begin
      cnt_d = CntLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntOne;
    end else begin
      cnt_d = cnt_q;
    end

    q_d = (sw_val & ~(expiry ? PulseMask : '0)) | hw_set_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q       <= ResetValue;
      cnt_q     <= '0;
      blocked_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      blocked_q <= wr_blocked;
    end
  end

  if (ShadowCopy) begin : g_shadow
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        shadow_q <= ~ResetValue;
      end else begin
        shadow_q <= ~q_d;
      end
    end
  end else begin : g_no_shadow
    // Without a shadow the comparison below is constant-false.
    assign shadow_q = ~q_q;
  end

  assign rd_data_o      = q_q;
  assign pulse_active_o = (cnt_q != '0);
  assign wr_blocked_o   = blocked_q;
  assign rd_error_o     = (q_q != ~shadow_q);

endmodule

// File: tb/tb_ibex_csr_pulse.sv
// tb/tb_ibex_csr_pulse.sv - bench for ibex_csr_pulse: three configurations checked
// against a deadline-based reference model with directed and random stimulus.
module tb_ibex_csr_pulse;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en [N];
  logic [1:0]  wr_op [N];
  logic [31:0] wr_data [N];
  logic        pulse_en [N];
  logic        lock [N];
  logic [31:0] hw_set [N];
  logic [31:0] rd_data [N];
  logic        pulse_active [N];
  logic        wr_blocked [N];
  logic        rd_error [N];

  logic [31:0] m_q [N];
  longint      m_dl [N];
  logic        m_blk [N];
  longint      t = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] shadow_bad;

  always #5 clk = ~clk;

  ibex_csr_pulse #(.Width(32), .ShadowCopy(1'b1), .PulseMask(32'h20), .PulseCycles(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en[0]), .wr_op_i(wr_op[0]),
    .wr_data_i(wr_data[0]), .pulse_en_i(pulse_en[0]), .lock_i(lock[0]),
    .hw_set_i(hw_set[0]), .rd_data_o(rd_data[0]), .pulse_active_o(pulse_active[0]),
    .wr_blocked_o(wr_blocked[0]), .rd_error_o(rd_error[0]));

  ibex_csr_pulse #(.Width(32), .PulseMask(32'h20), .PulseCycles(1)) dut_p1 (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en[1]), .wr_op_i(wr_op[1]),
    .wr_data_i(wr_data[1]), .pulse_en_i(pulse_en[1]), .lock_i(lock[1]),
    .hw_set_i(hw_set[1]), .rd_data_o(rd_data[1]), .pulse_active_o(pulse_active[1]),
    .wr_blocked_o(wr_blocked[1]), .rd_error_o(rd_error[1]));

  ibex_csr_pulse #(.Width(32), .ResetValue(32'hF0), .WriteMask(32'h0F)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en[2]), .wr_op_i(wr_op[2]),
    .wr_data_i(wr_data[2]), .pulse_en_i(pulse_en[2]), .lock_i(lock[2]),
    .hw_set_i(hw_set[2]), .rd_data_o(rd_data[2]), .pulse_active_o(pulse_active[2]),
    .wr_blocked_o(wr_blocked[2]), .rd_error_o(rd_error[2]));

  function automatic logic [31:0] wm(int i);
    return (i == 2) ? 32'h0000_000F : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] pm(int i);
    return (i == 2) ? 32'h0 : 32'h20;
  endfunction
  function automatic longint pc(int i);
    return (i == 0) ? 64'd4 : 64'd1;
  endfunction
  function automatic logic [31:0] rv(int i);
    return (i == 2) ? 32'hF0 : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, act, exp, t);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      wr_en[i] = 1'b0; wr_op[i] = 2'b00; wr_data[i] = '0;
      pulse_en[i] = 1'b0; lock[i] = 1'b0; hw_set[i] = '0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_q[i] = rv(i); m_dl[i] = -1; m_blk[i] = 1'b0;
    end
  endtask

  // One clock edge: advance the model with the applied inputs, then compare.
  task automatic step();
    logic [31:0] d, sw;
    logic acc, arm, ex;
    @(posedge clk);
    t++;
    for (int i = 0; i < N; i++) begin
      acc = wr_en[i] && !lock[i] && (wr_op[i] != 2'b11);
      d   = wr_data[i] & wm(i);
      sw  = m_q[i];
      if (acc && wr_op[i] == 2'b00) sw = (m_q[i] & ~wm(i)) | d;
      if (acc && wr_op[i] == 2'b01) sw = m_q[i] | d;
      if (acc && wr_op[i] == 2'b10) sw = m_q[i] & ~d;
      arm = acc && pulse_en[i] && ((sw & pm(i)) != 0);
      ex  = !arm && (m_dl[i] == t);
      if (arm) m_dl[i] = t + pc(i);
      m_q[i]   = (ex ? (sw & ~pm(i)) : sw) | hw_set[i];
      m_blk[i] = wr_en[i] && lock[i] && (wr_op[i] != 2'b11);
    end
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rd_data[%0d]", i), rd_data[i], m_q[i]);
      chk($sformatf("pulse_active[%0d]", i), 32'(pulse_active[i]), 32'(m_dl[i] > t));
      chk($sformatf("wr_blocked[%0d]", i), 32'(wr_blocked[i]), 32'(m_blk[i]));
      chk($sformatf("rd_error[%0d]", i), 32'(rd_error[i]), 32'h0);
    end
  endtask

  initial begin
    int high;
    idle_all();
    model_reset();
    #12;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset_rd[%0d]", i), rd_data[i], rv(i));
      chk($sformatf("reset_active[%0d]", i), 32'(pulse_active[i]), 32'h0);
      chk($sformatf("reset_blocked[%0d]", i), 32'(wr_blocked[i]), 32'h0);
      chk($sformatf("reset_error[%0d]", i), 32'(rd_error[i]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // PulseCycles=1: 0x21 armed -> 0x21 for one cycle, then 0x01
    wr_en[1] = 1'b1; wr_data[1] = 32'h21; pulse_en[1] = 1'b1;
    step(); idle_all();
    chk("p1_pulse_set", rd_data[1], 32'h21);
    chk("p1_active", 32'(pulse_active[1]), 32'h1);
    step();
    chk("p1_pulse_clr", rd_data[1], 32'h01);
    chk("p1_inactive", 32'(pulse_active[1]), 32'h0);

    // PulseCycles=4 with a re-arm three cycles in: 7 cycles high
    wr_en[0] = 1'b1; wr_data[0] = 32'h20; pulse_en[0] = 1'b1;
    step(); idle_all();
    high = rd_data[0][5] ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        wr_en[0] = 1'b1; wr_data[0] = 32'h20; pulse_en[0] = 1'b1;
      end
      step(); idle_all();
      if (rd_data[0][5]) high++;
      else break;
    end
    chk("rearm_high_cycles", 32'(high), 32'd7);

    // WriteMask=0x0F from 0xF0: write, clear, set, hw_set
    wr_en[2] = 1'b1; wr_op[2] = 2'b00; wr_data[2] = 32'hFF;
    step(); chk("mask_write", rd_data[2], 32'hFF);
    wr_op[2] = 2'b10; wr_data[2] = 32'h03;
    step(); chk("mask_clear", rd_data[2], 32'hFC);
    wr_op[2] = 2'b01; wr_data[2] = 32'h30;
    step(); chk("mask_set", rd_data[2], 32'hFC);
    idle_all(); hw_set[2] = 32'h100;
    step(); chk("hw_set", rd_data[2], 32'h1FC);
    idle_all(); wr_en[2] = 1'b1; lock[2] = 1'b1; wr_data[2] = 32'hAA;
    step(); chk("locked_rd", rd_data[2], 32'h1FC);
    chk("locked_flag", 32'(wr_blocked[2]), 32'h1);
    idle_all();
    step(); chk("locked_flag_drop", 32'(wr_blocked[2]), 32'h0);
    wr_en[2] = 1'b1; wr_op[2] = 2'b11; wr_data[2] = 32'h0;
    step(); idle_all();
    chk("op11_rd", rd_data[2], 32'h1FC);
    chk("op11_flag", 32'(wr_blocked[2]), 32'h0);

    // Sticky pulse bit, then hw_set on the expiry cycle
    wr_en[1] = 1'b1; wr_data[1] = 32'h20; pulse_en[1] = 1'b0;
    step(); idle_all();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("sticky_bit5", 32'(rd_data[1][5]), 32'h1);
    end
    wr_en[1] = 1'b1; wr_data[1] = 32'h20; pulse_en[1] = 1'b1;
    step(); idle_all(); hw_set[1] = 32'h20;
    step(); idle_all();
    chk("hw_at_expiry", rd_data[1], 32'h20);
    chk("hw_at_expiry_inactive", 32'(pulse_active[1]), 32'h0);

    // Shadow corruption seen combinationally, repaired by the next write
    step();
    shadow_bad = ~rd_data[0] ^ 32'h4;
    force dut.shadow_q = shadow_bad;
    #1;
    chk("shadow_error", 32'(rd_error[0]), 32'h1);
    release dut.shadow_q;
    wr_en[0] = 1'b1; wr_data[0] = 32'h3;
    step(); idle_all();
    chk("shadow_repaired", 32'(rd_error[0]), 32'h0);

    // Asynchronous reset in the middle of a countdown
    wr_en[0] = 1'b1; wr_data[0] = 32'h20; pulse_en[0] = 1'b1;
    step(); idle_all();
    step(); step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("midrst_rd[%0d]", i), rd_data[i], rv(i));
      chk($sformatf("midrst_active[%0d]", i), 32'(pulse_active[i]), 32'h0);
      chk($sformatf("midrst_error[%0d]", i), 32'(rd_error[i]), 32'h0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wr_en[0] = 1'b1; wr_data[0] = 32'h20; pulse_en[0] = 1'b0;
    step(); idle_all();
    for (int k = 0; k < 6; k++) step();
    chk("no_late_clear", rd_data[0], 32'h20);

    // Random traffic on all three instances
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        wr_en[i]    = 1'($urandom_range(0, 1));
        wr_op[i]    = 2'($urandom_range(0, 3));
        wr_data[i]  = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 255));
        pulse_en[i] = 1'($urandom_range(0, 1));
        lock[i]     = ($urandom_range(0, 4) == 0);
        hw_set[i]   = ($urandom_range(0, 7) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'h0;
      end
      step();
    end
    idle_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ibex_csr_pulse.md
# ibex_csr_pulse

Parametrised control/status register primitive for the Ibex CSR file, with per-bit write masking, set/clear write operations, hardware set inputs and a software lock. Configurable self-clearing "pulse" bits stay set for a programmable number of cycles after an armed write. Optional shadow copy provides fault detection. Instantiated once per architectural or custom CSR inside the CSR block.

## Interface
- Width, 32, register width in bits
- ShadowCopy, 1'b0, instantiate inverted shadow register and mismatch check
- ResetValue, '0, register value after reset
- WriteMask, '1, bits software may modify; other bits change only via hw_set_i
- PulseMask, '0, self-clearing bits; must be a subset of WriteMask (elaboration assertion)
- PulseCycles, 1, cycles a pulse bit stays set after an armed write; must be ≥1
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- wr_en_i  input  1  software write strobe
- wr_op_i  input  2  00 write, 01 set bits, 10 clear bits, 11 reserved (no-op)
- wr_data_i  input  Width  write operand
- pulse_en_i  input  1  arms the pulse countdown for this write
- lock_i  input  1  blocks software writes while high
- hw_set_i  input  Width  hardware set, per bit, every cycle
- rd_data_o  output  Width  current register value
- pulse_active_o  output  1  pulse countdown running
- wr_blocked_o  output  1  one-cycle flag: previous write was rejected by lock_i
- rd_error_o  output  1  shadow mismatch (0 when ShadowCopy=0)

## Operation
- Write accepted when wr_en_i=1, lock_i=0 and wr_op_i≠11.
- Software result sw: write → (q & ~WriteMask) | (wr_data_i & WriteMask); set → q | (wr_data_i & WriteMask); clear → q & ~(wr_data_i & WriteMask); not accepted → q.
- Arm: the write is accepted, pulse_en_i=1 and (sw & PulseMask)≠0. On arm the counter loads PulseCycles; it reloads if it was already running.
- Counter width $clog2(PulseCycles+1). It decrements each cycle when nonzero and no arm occurs.
- Expiry: counter==1 and no arm → PulseMask bits cleared and counter goes to 0.
- Next value: ((sw & ~(expiry ? PulseMask : 0)) | hw_set_i). hw_set_i has the highest priority, overrides expiry and WriteMask, and never arms.
- Pulse bits written with pulse_en_i=0 are sticky until software clears them. A running countdown still clears them at expiry.
- A non-arming accepted write during a countdown does not disturb the counter.
- Blocked write (wr_en_i=1, lock_i=1, op≠11): register unchanged, counter unaffected, wr_blocked_o=1 next cycle for exactly one cycle.
- Op 11: ignored silently. No blocked flag.
- Shadow: shadow_q ← ~next value on every cycle q updates, from any source. rd_error_o = (q ≠ ~shadow_q), combinational.
- ResetValue pulse bits do not arm the counter.

## Timing
- Reset values: rd_data_o=ResetValue, counter=0, pulse_active_o=0, wr_blocked_o=0, shadow=~ResetValue, rd_error_o=0.
- Write at edge N is visible on rd_data_o after edge N. There is no read latency; rd_data_o is the register output.
- Armed pulse bit is set from edge N and cleared at edge N+PulseCycles, so it is visible for exactly PulseCycles cycles.
- pulse_active_o is high from edge N through edge N+PulseCycles.
- Re-arm on the expiry cycle: the write takes effect, there is no clear, and the counter reloads.
- hw_set_i asserted at expiry keeps its bits set.
- Reset mid-countdown: all state returns to reset values immediately (asynchronous). No clear is pending after release.

## Test plan
- Defaults, PulseMask=0x20, PulseCycles=1: write 0x21 with pulse_en_i=1 → rd 0x21 for one cycle, then 0x01; pulse_active_o high for 1 cycle.
- PulseCycles=4, PulseMask=0x20: armed write 0x20, re-arm at cycle 3 → bit 5 stays high for 3+4=7 cycles total, then clears.
- WriteMask=0x0F, q=0xF0: write 0xFF → 0xFF; clear op 0x03 → 0xFC; set op 0x30 → 0xFC unchanged. Then hw_set_i=0x100 for one cycle → 0x1FC.
- lock_i=1, write 0xAA → rd unchanged, wr_blocked_o=1 the next cycle only. Op 11 with lock_i=0 → no change, no flag.
- Pulse write with pulse_en_i=0 → bit stays set ≥10 cycles. Same-cycle expiry and hw_set_i[5]=1 → bit 5 remains 1.
- ShadowCopy=1: force shadow_q bit flip → rd_error_o=1 the same cycle. A subsequent write restores rd_error_o=0. Assert rst_ni low mid-countdown → all reset values, no late clear.
